// File: rtl/ultrasonic_echo_emu_pkg.sv
// Shared types and constants for the ultrasonic echo emulator, echo counter and
// trigger generator.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTrigHi,
    StBurst,
    StEcho,
    StHoldoff
  } state_e;

  // Echo width register and echo counter width; holds TIMEOUT_CYC plus jitter.
  localparam int unsigned EchoW = 21;
  typedef logic [EchoW-1:0] echo_cnt_t;

  localparam int unsigned DistW = 9;

  localparam int unsigned DefCycPerCm   = 1566;
  localparam int unsigned DefTimeoutCyc = 1026000;
  localparam int unsigned DefBurstCyc   = 5400;

  localparam logic [15:0] LfsrSeed = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
  function automatic logic [15:0] lfsr_step(logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

endpackage

// File: rtl/ultrasonic_echo_emu_if.sv
// Trigger/echo signal bundle between the initiator (master) and the emulated
// sensor (slave).
interface ultrasonic_echo_emu_if;

  logic                             trig;
  logic [ultrasonic_pkg::DistW-1:0] dist_cm;
  logic                             echo;
  logic                             busy;
  logic                             trig_err;

  modport slave (
    input  trig,
    input  dist_cm,
    output echo,
    output busy,
    output trig_err
  );

  modport master (
    output trig,
    output dist_cm,
    input  echo,
    input  busy,
    input  trig_err
  );

endinterface

// File: rtl/ultrasonic_echo_emu_trig_sync.sv
// Trigger synchronizer: 2-FF synchronizer, edge register and registered
// single-cycle rise/fall strobes. Input edge to strobe is 3 clk cycles.
module trig_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync2_q, prev_q, rise_q, fall_q;

  // Synchronize trig, keep one cycle of history and register the edge strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= trig;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
      fall_q  <= ~sync2_q & prev_q;
    end
  end

  // prev_q is aligned with the strobes: high from the rise strobe cycle up to
  // the cycle before the fall strobe.
  assign level = prev_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ultrasonic_echo_emu.sv
// Ultrasonic sensor responder emulator: validates the trigger width, waits the
// burst delay, then drives an echo pulse whose width encodes dist_cm.
// Optional feature: define ECHO_JITTER_EN to add 0..255 cycles of LFSR jitter
// to each echo width.
module ultrasonic_echo_emu
  import ultrasonic_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 27000000,
  parameter int unsigned TRIG_MIN_CYC = 270,
  parameter int unsigned BURST_CYC    = DefBurstCyc,
  parameter int unsigned CYC_PER_CM   = DefCycPerCm,
  parameter int unsigned MAX_CM       = 400,
  parameter int unsigned TIMEOUT_CYC  = DefTimeoutCyc,
  parameter int unsigned HOLDOFF_CYC  = 27000
) (
  input logic                  clk,
  input logic                  rst_n,
  ultrasonic_echo_emu_if.slave bus
);

  if (CLK_HZ == 0 || TRIG_MIN_CYC == 0) begin : g_param_check
    $error("CLK_HZ and TRIG_MIN_CYC must be nonzero");
  end

  localparam int unsigned TcntW = $clog2(TRIG_MIN_CYC + 1);
  typedef logic [TcntW-1:0] tcnt_t;
  localparam tcnt_t TrigMin = tcnt_t'(TRIG_MIN_CYC);

  state_e    state_q, state_d;
  tcnt_t     tcnt_q, tcnt_d;
  echo_cnt_t cnt_q, cnt_d;
  echo_cnt_t width_q, width_d;
  echo_cnt_t width_base, width_new;
  logic      echo_q, busy_q, err_q, err_d;
  logic      trig_lvl, trig_rise, trig_fall;

  trig_sync u_trig_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .trig  (bus.trig),
    .level (trig_lvl),
    .rise  (trig_rise),
    .fall  (trig_fall)
  );

  // Echo width from the live distance; only latched on trigger acceptance.
  always_comb begin
    width_base = echo_cnt_t'(TIMEOUT_CYC);
    if (bus.dist_cm != '0 && 32'(bus.dist_cm) <= MAX_CM) begin
      width_base = echo_cnt_t'(bus.dist_cm) * echo_cnt_t'(CYC_PER_CM);
    end
  end

`ifdef ECHO_JITTER_EN
  logic [15:0] lfsr_q, lfsr_next;

  assign lfsr_next = lfsr_step(lfsr_q);
  // The jitter is the LFSR value after this acceptance's advance.
  assign width_new = width_base + echo_cnt_t'(lfsr_next[7:0]);

  // Advance the LFSR once per accepted trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LfsrSeed;
    end else if (state_q == StTrigHi && state_d == StBurst) begin
      lfsr_q <= lfsr_next;
    end
  end
`else
  assign width_new = width_base;
`endif

  // Next-state logic. cnt is a shared down-counter reloaded on every phase
  // change; a phase ends in the cycle its count reaches 1.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trig_rise) begin
          state_d = StTrigHi;
          tcnt_d  = '0;
        end
      end
      StTrigHi: begin
        if (trig_fall) begin
          tcnt_d = '0;
          if (tcnt_q >= TrigMin) begin
            state_d = StBurst;
            width_d = width_new;
            // Fall strobe cycle counts as the first burst delay cycle.
            cnt_d   = echo_cnt_t'(BURST_CYC - 1);
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end else if (trig_lvl && tcnt_q < TrigMin) begin
          tcnt_d = tcnt_q + tcnt_t'(1);
        end
      end
      StBurst: begin
        if (cnt_q <= echo_cnt_t'(1)) begin
          state_d = StEcho;
          cnt_d   = width_q;
        end else begin
          cnt_d = cnt_q - echo_cnt_t'(1);
        end
      end
      StEcho: begin
        if (cnt_q <= echo_cnt_t'(1)) begin
          state_d = StHoldoff;
          cnt_d   = echo_cnt_t'(HOLDOFF_CYC);
        end else begin
          cnt_d = cnt_q - echo_cnt_t'(1);
        end
      end
      StHoldoff: begin
        if (cnt_q <= echo_cnt_t'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - echo_cnt_t'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        tcnt_d  = '0;
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tcnt_q  <= '0;
      cnt_q   <= '0;
      width_q <= '0;
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      echo_q  <= (state_d == StEcho);
      busy_q  <= (state_d != StIdle);
      err_q   <= err_d;
    end
  end

  assign bus.echo     = echo_q;
  assign bus.busy     = busy_q;
  assign bus.trig_err = err_q;

endmodule

// File: tb/tb_ultrasonic_echo_emu.sv
// Directed bench for ultrasonic_echo_emu with a scoreboard of expected echo
// results. Timing constants are scaled down to keep runs short.
module tb_ultrasonic_echo_emu;

  localparam int unsigned TMIN  = 270;
  localparam int unsigned BURST = 54;
  localparam int unsigned CPC   = 15;
  localparam int unsigned MAXCM = 400;
  localparam int unsigned TOUT  = 10260;
  localparam int unsigned HOLD  = 270;
  localparam int unsigned RISE  = 3 + BURST;  // trig fall to echo rise

  typedef struct {
    bit          accept;
    int unsigned width;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fails = 0;
  logic [15:0] lfsr_m;

  always #5 clk = ~clk;

  ultrasonic_echo_emu_if bus ();

  ultrasonic_echo_emu #(
    .CLK_HZ       (27000000),
    .TRIG_MIN_CYC (TMIN),
    .BURST_CYC    (BURST),
    .CYC_PER_CM   (CPC),
    .MAX_CM       (MAXCM),
    .TIMEOUT_CYC  (TOUT),
    .HOLDOFF_CYC  (HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input bit acc, input int unsigned d);
    exp_t e;
    e.accept = acc;
    e.width  = (d == 0 || d > MAXCM) ? TOUT : d * CPC;
`ifdef ECHO_JITTER_EN
    if (acc) begin
      lfsr_m  = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
      e.width = e.width + int'(lfsr_m[7:0]);
    end
`endif
    sb.push_back(e);
  endtask

  // Trigger high for h cycles from idle; checks busy rises one cycle after
  // the rise strobe (4 cycles after trig rises).
  task automatic pulse_trig(input int unsigned h, input int unsigned d);
    @(negedge clk);
    bus.dist_cm = 9'(d);
    bus.trig    = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_pre_rise", bus.busy, 0);
    @(negedge clk);
    check("busy_rise", bus.busy, 1);
    repeat (h - 4) @(negedge clk);
    bus.trig = 1'b0;
  endtask

  // Watch the DUT from trig fall until busy drops; optional trig injection.
  task automatic observe(input int unsigned inj_on, input int unsigned inj_off);
    exp_t        e;
    int unsigned n = 0, rise_n = 0, fall_n = 0, err_n = 0, err_cnt = 0;
    int unsigned width = 0, busy_n = 0;
    bit          done = 0;
    int unsigned bound = RISE + TOUT + 256 + HOLD + 50;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
      if (inj_on != 0 && n == inj_on) bus.trig = 1'b1;
      if (inj_off != 0 && n == inj_off) bus.trig = 1'b0;
      if (n == 5) bus.dist_cm = 9'd3;
      if (bus.echo) begin
        if (width == 0) rise_n = n;
        width++;
      end else if (width != 0 && fall_n == 0) begin
        fall_n = n;
      end
      if (bus.trig_err) begin
        err_cnt++;
        err_n = n;
      end
      if (!bus.busy) begin
        busy_n = n;
        done   = 1;
      end
    end
    check("busy_done_in_bound", done, 1);
    check("scoreboard_nonempty", sb.size(), sb.size() == 0 ? 1 : sb.size());
    if (sb.size() == 0) return;
    e = sb.pop_front();
    if (e.accept) begin
      check("echo_rise_delay", rise_n, RISE);
      check("echo_width", width, e.width);
      check("holdoff_len", busy_n - fall_n, HOLD);
      check("no_trig_err", err_cnt, 0);
    end else begin
      check("trig_err_count", err_cnt, 1);
      check("trig_err_time", err_n, 4);
      check("reject_no_echo", width, 0);
      check("reject_busy_fall", busy_n, 4);
    end
    @(negedge clk);
    check("trig_err_one_cycle", bus.trig_err, 0);
  endtask

  task automatic send(input int unsigned h, input int unsigned d, input bit acc,
                      input int unsigned inj_on, input int unsigned inj_off);
    push_expected(acc, d);
    pulse_trig(h, d);
    observe(inj_on, inj_off);
  endtask

  initial begin
    int unsigned busy_hi;
    bit          seen;
    bus.trig    = 1'b0;
    bus.dist_cm = '0;
    lfsr_m      = 16'hACE1;
    repeat (3) @(negedge clk);
    check("reset_echo", bus.echo, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_trig_err", bus.trig_err, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send(300, 100, 1, 0, 0);
    send(200, 100, 0, 0, 0);
    send(300, 0, 1, 0, 0);
    send(300, 450, 1, 0, 0);
    send(300, 400, 1, 0, 0);
    send(300, 1, 1, 0, 0);

    // Second trigger during ECHO is ignored.
    send(300, 100, 1, RISE + 20, RISE + 320);
    // Trigger raised late in HOLDOFF and held into IDLE is ignored.
    send(300, 100, 1, RISE + 100 * CPC + HOLD - 50, 0);
    busy_hi = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.busy || bus.echo) busy_hi++;
    end
    check("held_trig_ignored", busy_hi, 0);
    bus.trig = 1'b0;
    repeat (10) @(negedge clk);
    send(300, 100, 1, 0, 0);

    // Reset in the middle of an echo abandons it.
    pulse_trig(300, 50);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (bus.echo) seen = 1;
    end
    check("pre_reset_echo_seen", seen, 1);
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_echo", bus.echo, 0);
    check("async_reset_busy", bus.busy, 0);
    @(negedge clk);
    check("reset_hold_echo", bus.echo, 0);
    lfsr_m = 16'hACE1;
    rst_n  = 1'b1;
    repeat (5) @(negedge clk);
    send(300, 10, 1, 0, 0);
    send(300, 100, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ultrasonic_echo_emu.md
# ultrasonic_echo_emu

Synthesizable emulator of the responder end of the ultrasonic ranging protocol. It accepts the 10 µs trigger pulse produced by the radar's trigger generator and answers with an echo pulse whose width encodes a programmed distance. It runs on the board's 27 MHz clock, replacing the physical sensor for hardware-in-loop testing of the echo counter, distance calculation and display chain.

## Interface
- CLK_HZ, 27000000, clock frequency; documentation only.
- TRIG_MIN_CYC, 270, minimum accepted trigger high time (10 µs).
- BURST_CYC, 5400, emulated 8-cycle 40 kHz burst delay (200 µs) between accepted trigger and echo rise.
- CYC_PER_CM, 1566, echo cycles per cm (58 µs/cm).
- MAX_CM, 400, largest in-range distance.
- TIMEOUT_CYC, 1026000, no-target echo width (38 ms).
- HOLDOFF_CYC, 27000, dead time after echo fall (1 ms).
- clk  in  1  system clock, posedge only.
- rst_n  in  1  asynchronous active-low reset.
- trig  in  1  asynchronous trigger from the initiator.
- dist_cm  in  9  programmed target distance, sampled at trigger acceptance.
- echo  out  1  echo pulse to the receiver.
- busy  out  1  high in every state except IDLE.
- trig_err  out  1  one-cycle pulse on a rejected (short) trigger.

## Operation
- trig passes a 2-FF synchronizer plus one edge register; rise/fall are single-cycle strobes.
- States: IDLE, TRIG_HI, BURST, ECHO, HOLDOFF.
- IDLE: on rise -> TRIG_HI, clear tcnt. Only a rise seen in IDLE starts a transaction; trig already high on entering IDLE is ignored until it falls and rises again.
- TRIG_HI: tcnt increments every cycle while synced trig is high, saturating at TRIG_MIN_CYC. On fall: tcnt >= TRIG_MIN_CYC -> latch dist_cm, -> BURST; otherwise pulse trig_err, -> IDLE.
- Echo width W computed on acceptance: dist_cm == 0 or dist_cm > MAX_CM -> TIMEOUT_CYC; else dist_cm * CYC_PER_CM (max 626400). W register and echo counter are 21 bits, unsigned, no truncation.
- BURST: count BURST_CYC cycles, -> ECHO.
- ECHO: echo high exactly W cycles, then -> HOLDOFF.
- HOLDOFF: count HOLDOFF_CYC cycles, -> IDLE.
- trig activity in BURST/ECHO/HOLDOFF is ignored; no queuing. dist_cm changes after acceptance have no effect on the current echo.
- Reset mid-operation: all outputs and state return to reset values immediately; a pending echo is abandoned.

## Timing
- Reset values: echo 0, busy 0, trig_err 0, state IDLE, all counters 0.
- trig edge to internal strobe: 3 clk cycles.
- Fall strobe cycle to echo rise: BURST_CYC cycles. Echo high: W cycles. Echo fall to IDLE: HOLDOFF_CYC cycles.
- trig_err asserts the cycle after the fall strobe, for 1 cycle.
- busy rises the cycle after the rise strobe and falls on the cycle IDLE is re-entered.
- All outputs are registered.

## Configuration
- ECHO_JITTER_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per accepted trigger; its low 8 bits are added to W (0..255 extra cycles).
- ECHO_JITTER_EN undefined: no LFSR; W exactly as specified above.

## Structure
- Package ultrasonic_pkg: state enum, 21-bit width constant, default CYC_PER_CM / TIMEOUT_CYC / BURST_CYC values shared with the echo counter and trigger generator.
- One sub-module: trig_sync (2-FF synchronizer, edge register, rise/fall strobes, async active-low reset).

## Test plan
- Trig high 300 cycles, dist_cm=100 -> echo rises 5400 cycles after fall strobe, high exactly 156600 cycles, busy until 27000 cycles after echo fall.
- Trig high 200 cycles -> trig_err one-cycle pulse, echo stays 0, busy returns low, no BURST entered.
- dist_cm=0 and dist_cm=450 -> echo width 1026000; dist_cm=400 -> 626400; dist_cm=1 -> 1566.
- Second trigger during ECHO and one held high across HOLDOFF->IDLE -> both ignored; next fresh 300-cycle trigger accepted.
- rst_n asserted mid-ECHO -> echo, busy low asynchronously; after release, a 300-cycle trigger produces a normal echo.
- ECHO_JITTER_EN defined, dist_cm=10 -> first echo width 15660 + (LFSR value after first advance from 16'hACE1)[7:0], checked against a reference LFSR model.
